// File: rtl/icache_refill_ctrl_pkg.sv
// Shared types and defaults for the instruction-cache refill controller.
// Holds the refill FSM encoding and the line geometry.
package icache_refill_ctrl_pkg;

  localparam int DEF_ADDR_W       = 64;
  localparam int DEF_LINE_W       = 128;
  localparam int DEF_CNT_W        = 32;
  localparam int DEF_TIMEOUT      = 256;
  localparam int LINE_OFFSET_BITS = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_REQ    = 2'd1,
    ST_FILL   = 2'd2,
    ST_RESUME = 2'd3
  } refill_state_e;

endpackage

// File: rtl/icache_refill_ctrl_sat.sv
// Width-parameterized saturating incrementer with synchronous clear.
// Holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clock,
  input  logic         clear,
  input  logic         inc,
  output logic [W-1:0] count
);

  // Count register: clear dominates, then saturating increment.
  always_ff @(posedge clock) begin
    if (clear) begin
      count <= {W{1'b0}};
    end else if (inc && (count != {W{1'b1}})) begin
      count <= count + W'(1);
    end else begin
      count <= count;
    end
  end

endmodule

// File: rtl/icache_refill_ctrl.sv
// Instruction-cache miss refill controller: stalls fetch, requests the
// missing line, writes it into the cache and resumes, with a request timeout.
module icache_refill_ctrl
  import icache_refill_ctrl_pkg::*;
#(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int LINE_W  = DEF_LINE_W,
  parameter int CNT_W   = DEF_CNT_W,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              lookup_valid,
  input  logic              hit,
  input  logic [ADDR_W-1:0] miss_address,
  input  logic              redirect,
  output logic              stall,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_address,
  input  logic              mem_ack,
  input  logic [LINE_W-1:0] mem_data_line,
  output logic              fill_en,
  output logic [ADDR_W-1:0] fill_address,
  output logic [LINE_W-1:0] fill_data,
  output logic              error,
  output logic [CNT_W-1:0]  miss_count
);

  localparam int TO_W = $clog2(TIMEOUT + 1);
  localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'((1 << LINE_OFFSET_BITS) - 1);

  refill_state_e     state_r;
  refill_state_e     state_s;
  logic [ADDR_W-1:0] line_addr_r;
  logic [LINE_W-1:0] data_r;
  logic [TO_W-1:0]   to_cnt_r;
  logic              miss_accept_s;
  logic              timeout_s;

  // A redirected miss is a wrong-path fetch and is dropped.
  assign miss_accept_s = !reset && (state_r == ST_IDLE) && lookup_valid && !hit && !redirect;
  // An ack on the terminal-count cycle still wins over the timeout.
  assign timeout_s     = !reset && (state_r == ST_REQ) && !mem_ack &&
                         (to_cnt_r == TO_W'(TIMEOUT - 1));

  // Next-state decode; redirect deliberately plays no part once a refill is running.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (miss_accept_s) state_s = ST_REQ;
        else               state_s = ST_IDLE;
      end
      ST_REQ: begin
        if (mem_ack)        state_s = ST_FILL;
        else if (timeout_s) state_s = ST_IDLE;
        else                state_s = ST_REQ;
      end
      ST_FILL:   state_s = ST_RESUME;
      ST_RESUME: state_s = ST_IDLE;
      default:   state_s = ST_IDLE;
    endcase
  end

  // State, latched line address/data and request timeout counter.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r     <= ST_IDLE;
      line_addr_r <= {ADDR_W{1'b0}};
      data_r      <= {LINE_W{1'b0}};
      to_cnt_r    <= {TO_W{1'b0}};
    end else begin
      state_r <= state_s;
      if (miss_accept_s) begin
        line_addr_r <= miss_address & ~OFF_MASK;
      end else begin
        line_addr_r <= line_addr_r;
      end
      if ((state_r == ST_REQ) && mem_ack) begin
        data_r <= mem_data_line;
      end else begin
        data_r <= data_r;
      end
      if (miss_accept_s) begin
        to_cnt_r <= {TO_W{1'b0}};
      end else if ((state_r == ST_REQ) && !mem_ack && !timeout_s) begin
        to_cnt_r <= to_cnt_r + TO_W'(1);
      end else begin
        to_cnt_r <= to_cnt_r;
      end
    end
  end

  assign stall        = miss_accept_s || (state_r != ST_IDLE);
  assign mem_req      = (state_r == ST_REQ);
  assign mem_address  = line_addr_r;
  assign fill_en      = (state_r == ST_FILL);
  assign fill_address = line_addr_r;
  assign fill_data    = data_r;
  assign error        = timeout_s;

  sat_counter #(.W(CNT_W)) u_miss_cnt (
    .clock (clock),
    .clear (reset),
    .inc   (miss_accept_s),
    .count (miss_count)
  );

endmodule
